image_preprocessing: RTL and testbench
======================================

IMAGE_PREPROCESSING -- requirements
Module: image_preprocessing

Interface
REQ-001 Parameter DATA_WIDTH, default 8: bits per colour channel.
REQ-002 Parameters MEAN_R/MEAN_G/MEAN_B, default 16 each: per-channel offset subtracted from the input, unsigned DATA_WIDTH.
REQ-003 Parameters SCALE_R/SCALE_G/SCALE_B, default 149 each: per-channel unsigned 8-bit gain.
REQ-004 Parameter SHIFT, default 7: arithmetic right shift applied after the gain.
REQ-005 Port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-006 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 Port enable, input, 1 bit: permits input acceptance.
REQ-008 Port frame_start, input, 1 bit: single-cycle pulse marking a new frame.
REQ-009 Port s_axis_tdata, input, 3*DATA_WIDTH bits: input pixel, R in bits [23:16], G in [15:8], B in [7:0].
REQ-010 Port s_axis_tvalid, input, 1 bit: input beat valid.
REQ-011 Port s_axis_tready, output, 1 bit: block can accept an input beat.
REQ-012 Port m_axis_tdata, output, 3*DATA_WIDTH bits: normalized pixel, same channel packing as the input.
REQ-013 Port m_axis_tvalid, output, 1 bit: output beat valid.
REQ-014 Port m_axis_tready, input, 1 bit: downstream accepts the output beat.

Function
REQ-015 Each channel result SHALL be computed as y = ((x - MEAN) * SCALE) >>> SHIFT, using signed arithmetic at least 2*DATA_WIDTH+2 bits wide with floor rounding.
REQ-016 The channel output SHALL be y clamped to the range 0..2^DATA_WIDTH-1; see REQ-029 for the unclamped build.
REQ-017 The pipeline SHALL have two register stages. Stage 1 registers the subtract and multiply; stage 2 registers the shift and clamp. Latency from input handshake to m_axis_tvalid is 2 cycles when the pipeline is not stalled.
REQ-018 Define advance = !m_axis_tvalid || m_axis_tready. When advance is high, all stages shift by one position. When advance is low, all stages hold their contents.
REQ-019 s_axis_tready SHALL equal enable && advance && !frame_start, computed combinationally.
REQ-020 An input beat SHALL be accepted only when s_axis_tvalid && s_axis_tready. An empty slot (valid = 0) propagates through the pipeline when no beat is accepted.
REQ-021 While m_axis_tvalid is high and m_axis_tready is low, m_axis_tdata and m_axis_tvalid SHALL remain stable. No beat is lost or duplicated, and beat order is preserved.
REQ-022 When enable is low, input acceptance SHALL be blocked, and beats already in flight SHALL still drain to the output.
REQ-023 A frame_start pulse SHALL synchronously clear all stage valid bits, including m_axis_tvalid, on the next rising edge, discarding any in-flight beats. No input beat is accepted in the frame_start cycle.
REQ-024 Under backpressure, full throughput of one beat per cycle SHALL be sustained whenever m_axis_tready is held high.

Reset
REQ-025 While rst_n is low, all valid bits, m_axis_tvalid and m_axis_tdata SHALL be 0.
REQ-026 Because s_axis_tready depends on enable, it SHALL follow REQ-019 combinationally after reset.
REQ-027 Asserting reset mid-stream SHALL discard all in-flight beats immediately; no partial output beat is produced.

Configuration
REQ-028 Macro IMG_PREPROC_CLAMP_EN defined: each channel output SHALL saturate per REQ-016.
REQ-029 Macro IMG_PREPROC_CLAMP_EN undefined: each channel output SHALL be the low DATA_WIDTH bits of y (wrap-around), with no clamp logic instantiated.

Verification
REQ-030 Build with the macro defined, default parameters, enable=1, m_axis_tready=1. Send R=16, G=100, B=255. Expect R=0, G=97, B=255 two cycles after acceptance.
REQ-031 Build with the macro defined. Send R=0, G=10, B=17. Expect R=0, G=0, B=1; negative results clamp to 0.
REQ-032 Build with the macro undefined. Send B=255. Expect B=22 (278 mod 256). Send G=100. Expect G=97.
REQ-033 Send 10 beats with m_axis_tready low for 5 cycles mid-stream. Expect all 10 outputs in order, tdata held stable while stalled, and s_axis_tready low during the stall.
REQ-034 Set enable=0 with s_axis_tvalid=1. Expect s_axis_tready=0, no new outputs, and earlier beats still delivered.
REQ-035 With 2 beats in flight, pulse frame_start. Expect m_axis_tvalid=0 on the next cycle and both beats discarded. Separately, assert rst_n low mid-stream and expect all outputs 0 immediately.

Source files
------------

// File: rtl/image_preprocessing.sv
// rtl/image_preprocessing.sv - per-channel mean/scale pixel normalisation, two-stage stallable pipeline
// Optional saturation of each channel result is enabled by defining IMG_PREPROC_CLAMP_EN;
// without it each channel wraps to its low DATA_WIDTH bits.
module image_preprocessing #(
   parameter int                    DATA_WIDTH = 8,
   parameter logic [DATA_WIDTH-1:0] MEAN_R     = 16,
   parameter logic [DATA_WIDTH-1:0] MEAN_G     = 16,
   parameter logic [DATA_WIDTH-1:0] MEAN_B     = 16,
   parameter logic [7:0]            SCALE_R    = 149,
   parameter logic [7:0]            SCALE_G    = 149,
   parameter logic [7:0]            SCALE_B    = 149,
   parameter int                    SHIFT      = 7
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    enable,
   input  logic                    frame_start,
   input  logic [3*DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                    s_axis_tvalid,
   output logic                    s_axis_tready,
   output logic [3*DATA_WIDTH-1:0] m_axis_tdata,
   output logic                    m_axis_tvalid,
   input  logic                    m_axis_tready
);

   // Signed working width: wide enough for (x - mean) * scale without overflow
   localparam int PW = 2*DATA_WIDTH + 2;

   logic r_v1;
   logic r_v2;
   logic w_advance;
   logic w_accept;

   // The whole pipeline moves together; it only freezes when the output slot is full and blocked
   assign w_advance     = !r_v2 || m_axis_tready;
   assign s_axis_tready = enable && w_advance && !frame_start;
   assign w_accept      = s_axis_tvalid && s_axis_tready;
   assign m_axis_tvalid = r_v2;

   // Stage valid bits: frame_start flushes everything in flight, otherwise shift on advance
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_v1 <= 1'b0;
         r_v2 <= 1'b0;
      end else if (frame_start) begin
         r_v1 <= 1'b0;
         r_v2 <= 1'b0;
      end else if (w_advance) begin
         r_v1 <= w_accept;
         r_v2 <= r_v1;
      end
   end

   for (genvar ch = 0; ch < 3; ch++) begin : g_ch
      // Channel 0 is B (lowest bits), 1 is G, 2 is R
      localparam logic [DATA_WIDTH-1:0] L_MEAN  = (ch == 0) ? MEAN_B  : ((ch == 1) ? MEAN_G  : MEAN_R);
      localparam logic [7:0]            L_SCALE = (ch == 0) ? SCALE_B : ((ch == 1) ? SCALE_G : SCALE_R);

      logic signed [PW-1:0]   w_diff;
      logic signed [PW-1:0]   w_prod;
      logic signed [PW-1:0]   w_y;
      logic signed [PW-1:0]   r_prod;
      logic [DATA_WIDTH-1:0]  w_out;
      logic [DATA_WIDTH-1:0]  r_out;

      assign w_diff = $signed({{(PW-DATA_WIDTH){1'b0}}, s_axis_tdata[ch*DATA_WIDTH +: DATA_WIDTH]})
                    - $signed({{(PW-DATA_WIDTH){1'b0}}, L_MEAN});
      assign w_prod = w_diff * $signed({{(PW-8){1'b0}}, L_SCALE});

      // Arithmetic shift of a signed value gives floor rounding for negative results
      assign w_y = r_prod >>> SHIFT;

`ifdef IMG_PREPROC_CLAMP_EN
      localparam logic signed [PW-1:0] L_MAX = $signed({{(PW-DATA_WIDTH){1'b0}}, {DATA_WIDTH{1'b1}}});

      // Saturate into the unsigned output range
      always_comb begin
         w_out = w_y[DATA_WIDTH-1:0];
         if (w_y < 0) begin
            w_out = '0;
         end else if (w_y > L_MAX) begin
            w_out = '1;
         end
      end
`else
      logic w_unused_hi;

      assign w_out       = w_y[DATA_WIDTH-1:0];
      assign w_unused_hi = ^w_y[PW-1:DATA_WIDTH];
`endif

      // Stage 1 holds the product, stage 2 the shifted/limited channel value
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_prod <= '0;
            r_out  <= '0;
         end else if (w_advance) begin
            r_prod <= w_prod;
            r_out  <= w_out;
         end
      end

      assign m_axis_tdata[ch*DATA_WIDTH +: DATA_WIDTH] = r_out;
   end

endmodule

// File: tb/tb_image_preprocessing.sv
// tb/tb_image_preprocessing.sv - directed self-checking bench for image_preprocessing
module tb_image_preprocessing;

   logic        clk;
   logic        rst_n;
   logic        enable;
   logic        frame_start;
   logic [23:0] s_tdata;
   logic        s_tvalid;
   logic        s_tready;
   logic [23:0] m_tdata;
   logic        m_tvalid;
   logic        m_tready;

   int n_tests;
   int n_fail;

   // floor(k*149/128) for input k+16 on every channel, worked by hand
   logic [7:0] exp_k [10];

`ifdef IMG_PREPROC_CLAMP_EN
   localparam logic [23:0] EXP_A = {8'd0, 8'd97, 8'd255};
   localparam logic [23:0] EXP_B = {8'd0, 8'd0, 8'd1};
`else
   localparam logic [23:0] EXP_A = {8'd0, 8'd97, 8'd22};
   localparam logic [23:0] EXP_B = {8'd237, 8'd249, 8'd1};
`endif

   image_preprocessing dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .enable        (enable),
      .frame_start   (frame_start),
      .s_axis_tdata  (s_tdata),
      .s_axis_tvalid (s_tvalid),
      .s_axis_tready (s_tready),
      .m_axis_tdata  (m_tdata),
      .m_axis_tvalid (m_tvalid),
      .m_axis_tready (m_tready)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic push_check(input string tag, input logic [23:0] pix, input logic [23:0] exp);
      s_tvalid = 1'b1;
      s_tdata  = pix;
      @(negedge clk);
      s_tvalid = 1'b0;
      #1;
      check({tag, "_lat1"}, {31'd0, m_tvalid}, 32'd0);
      @(negedge clk);
      #1;
      check({tag, "_valid"}, {31'd0, m_tvalid}, 32'd1);
      check({tag, "_data"}, {8'd0, m_tdata}, {8'd0, exp});
      @(negedge clk);
   endtask

   initial begin
      int          sent;
      int          recv;
      int          nout;
      logic        stalled_prev;
      logic [23:0] prev_data;

      exp_k = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd8, 8'd9, 8'd10};
      n_tests = 0;
      n_fail  = 0;
      clk = 1'b0;
      rst_n = 1'b0;
      enable = 1'b1;
      frame_start = 1'b0;
      s_tvalid = 1'b0;
      s_tdata = '0;
      m_tready = 1'b1;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_m_tvalid", {31'd0, m_tvalid}, 32'd0);
      check("rst_m_tdata", {8'd0, m_tdata}, 32'd0);
      check("rst_s_tready", {31'd0, s_tready}, 32'd1);
      enable = 1'b0;
      #1;
      check("rst_s_tready_en0", {31'd0, s_tready}, 32'd0);
      enable = 1'b1;
      rst_n = 1'b1;
      @(negedge clk);

      // Single pixels, positive / negative / overflow paths
      push_check("pix_a", {8'd16, 8'd100, 8'd255}, EXP_A);
      push_check("pix_b", {8'd0, 8'd10, 8'd17}, EXP_B);

      // Ten beats with a five-cycle downstream stall
      sent = 0;
      recv = 0;
      stalled_prev = 1'b0;
      prev_data = '0;
      for (int cyc = 0; cyc < 60 && recv < 10; cyc++) begin
         m_tready = !(cyc >= 4 && cyc < 9);
         s_tvalid = (sent < 10);
         s_tdata  = {3{8'(16 + sent)}};
         #1;
         if (stalled_prev) begin
            check("stall_hold_valid", {31'd0, m_tvalid}, 32'd1);
            check("stall_hold_data", {8'd0, m_tdata}, {8'd0, prev_data});
         end
         if (m_tvalid && !m_tready) begin
            check("stall_s_tready", {31'd0, s_tready}, 32'd0);
         end
         if (m_tvalid && m_tready) begin
            check($sformatf("stream_beat%0d", recv), {8'd0, m_tdata}, {8'd0, {3{exp_k[recv]}}});
            recv++;
         end
         stalled_prev = m_tvalid && !m_tready;
         prev_data = m_tdata;
         if (s_tvalid && s_tready) sent++;
         @(negedge clk);
      end
      s_tvalid = 1'b0;
      m_tready = 1'b1;
      check("stream_count", recv, 32'd10);
      repeat (2) @(negedge clk);

      // enable low blocks input but in-flight beats still drain
      nout = 0;
      for (int cyc = 0; cyc < 10; cyc++) begin
         enable   = (cyc < 2);
         s_tvalid = 1'b1;
         s_tdata  = {3{8'(17 + cyc)}};
         #1;
         if (cyc >= 2) check("en0_s_tready", {31'd0, s_tready}, 32'd0);
         if (m_tvalid) begin
            if (nout < 2) check("en0_drain_data", {8'd0, m_tdata}, {8'd0, {3{exp_k[nout+1]}}});
            nout++;
         end
         @(negedge clk);
      end
      s_tvalid = 1'b0;
      enable = 1'b1;
      check("en0_out_count", nout, 32'd2);
      repeat (2) @(negedge clk);

      // frame_start flushes two in-flight beats
      m_tready = 1'b0;
      s_tvalid = 1'b1;
      s_tdata  = {3{8'd17}};
      @(negedge clk);
      s_tdata  = {3{8'd18}};
      @(negedge clk);
      frame_start = 1'b1;
      s_tdata  = {3{8'd19}};
      #1;
      check("fs_s_tready", {31'd0, s_tready}, 32'd0);
      check("fs_inflight", {31'd0, m_tvalid}, 32'd1);
      @(negedge clk);
      frame_start = 1'b0;
      s_tvalid = 1'b0;
      #1;
      check("fs_cleared", {31'd0, m_tvalid}, 32'd0);
      m_tready = 1'b1;
      for (int cyc = 0; cyc < 4; cyc++) begin
         @(negedge clk);
         #1;
         check("fs_discarded", {31'd0, m_tvalid}, 32'd0);
      end

      // Asynchronous reset mid-stream
      @(negedge clk);
      s_tvalid = 1'b1;
      s_tdata  = {3{8'd100}};
      @(negedge clk);
      s_tdata  = {3{8'd200}};
      @(negedge clk);
      s_tvalid = 1'b0;
      #1;
      check("mid_pre_valid", {31'd0, m_tvalid}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", {31'd0, m_tvalid}, 32'd0);
      check("mid_rst_data", {8'd0, m_tdata}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int cyc = 0; cyc < 3; cyc++) begin
         @(negedge clk);
         #1;
         check("mid_rst_no_out", {31'd0, m_tvalid}, 32'd0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
